// File: rtl/atan2_cordic_pkg.sv
// ============================================================================
// atan2_cordic_pkg : fixed-point format and CORDIC constants for atan2_cordic
// Rev 1.0
// ============================================================================
`default_nettype none

package atan2_cordic_pkg;

   localparam int FLOAT_BITS        = 32;
   localparam int FLOAT_DCM_BITS    = 16;
   localparam int FLOAT_DOUBLE_BITS = 2 * FLOAT_BITS;

   // Q16.16 values, rounded to nearest
   localparam logic signed [FLOAT_BITS-1:0] PI              = 32'sd205887;
   localparam logic signed [FLOAT_BITS-1:0] CORDIC_INV_GAIN = 32'sd39797;

   localparam logic signed [FLOAT_BITS-1:0] ATAN_0  = 32'sd51472;
   localparam logic signed [FLOAT_BITS-1:0] ATAN_1  = 32'sd30386;
   localparam logic signed [FLOAT_BITS-1:0] ATAN_2  = 32'sd16055;
   localparam logic signed [FLOAT_BITS-1:0] ATAN_3  = 32'sd8150;
   localparam logic signed [FLOAT_BITS-1:0] ATAN_4  = 32'sd4091;
   localparam logic signed [FLOAT_BITS-1:0] ATAN_5  = 32'sd2047;
   localparam logic signed [FLOAT_BITS-1:0] ATAN_6  = 32'sd1024;
   localparam logic signed [FLOAT_BITS-1:0] ATAN_7  = 32'sd512;
   localparam logic signed [FLOAT_BITS-1:0] ATAN_8  = 32'sd256;
   localparam logic signed [FLOAT_BITS-1:0] ATAN_9  = 32'sd128;
   localparam logic signed [FLOAT_BITS-1:0] ATAN_10 = 32'sd64;
   localparam logic signed [FLOAT_BITS-1:0] ATAN_11 = 32'sd32;
   localparam logic signed [FLOAT_BITS-1:0] ATAN_12 = 32'sd16;
   localparam logic signed [FLOAT_BITS-1:0] ATAN_13 = 32'sd8;
   localparam logic signed [FLOAT_BITS-1:0] ATAN_14 = 32'sd4;
   localparam logic signed [FLOAT_BITS-1:0] ATAN_15 = 32'sd2;

endpackage

`default_nettype wire

// File: rtl/atan2_cordic_atan_table.sv
// ============================================================================
// atan_table : combinational ROM of atan(2^-i), zero for out-of-range indices
// Rev 1.0
// ============================================================================
`default_nettype none

module atan_table
   import atan2_cordic_pkg::*;
(
   input  logic [4:0]                   idx,
   output logic signed [FLOAT_BITS-1:0] angle
);

   always_comb begin
      angle = '0;
      case (idx)
         5'd0:    angle = ATAN_0;
         5'd1:    angle = ATAN_1;
         5'd2:    angle = ATAN_2;
         5'd3:    angle = ATAN_3;
         5'd4:    angle = ATAN_4;
         5'd5:    angle = ATAN_5;
         5'd6:    angle = ATAN_6;
         5'd7:    angle = ATAN_7;
         5'd8:    angle = ATAN_8;
         5'd9:    angle = ATAN_9;
         5'd10:   angle = ATAN_10;
         5'd11:   angle = ATAN_11;
         5'd12:   angle = ATAN_12;
         5'd13:   angle = ATAN_13;
         5'd14:   angle = ATAN_14;
         5'd15:   angle = ATAN_15;
         default: angle = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/atan2_cordic.sv
// ============================================================================
// atan2_cordic : iterative vectoring-mode CORDIC returning atan2(y, x) and |v|
// Rev 1.0
// ============================================================================
`default_nettype none

module atan2_cordic
   import atan2_cordic_pkg::*;
#(
   parameter int ITERATIONS = 16
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [FLOAT_BITS-1:0] in_x,
   input  logic signed [FLOAT_BITS-1:0] in_y,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [FLOAT_BITS-1:0] out_angle,
   output logic signed [FLOAT_BITS-1:0] out_mag
);

   localparam int         W    = FLOAT_BITS + 2;
   localparam logic [4:0] LAST = 5'(ITERATIONS - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ROTATE = 2'd1,
      SCALE  = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t                              state;
   logic signed [W-1:0]                 x, y, z;
   logic [4:0]                          iter;
   logic                                zero_vec;

   logic signed [FLOAT_BITS-1:0]        atan_i;
   logic signed [W-1:0]                 x_sh, y_sh, atan_w, ext_x, ext_y;
   logic signed [FLOAT_DOUBLE_BITS-1:0] prod;
   logic                                y_pos;

   atan_table u_atan_table (
      .idx   (iter),
      .angle (atan_i)
   );

   assign y_pos  = ~y[W-1];
   assign x_sh   = x >>> iter;
   assign y_sh   = y >>> iter;
   assign atan_w = W'(atan_i);
   assign ext_x  = W'(in_x);
   assign ext_y  = W'(in_y);
   assign prod   = FLOAT_DOUBLE_BITS'(x) * FLOAT_DOUBLE_BITS'(CORDIC_INV_GAIN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         x         <= '0;
         y         <= '0;
         z         <= '0;
         iter      <= '0;
         zero_vec  <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_angle <= '0;
         out_mag   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  in_ready <= 1'b0;
                  iter     <= '0;
                  zero_vec <= (in_x == '0) && (in_y == '0);
                  // Left half-plane: rotate by 180 deg so the core only sees x >= 0
                  if (in_x[FLOAT_BITS-1]) begin
                     x <= -ext_x;
                     y <= -ext_y;
                     z <= in_y[FLOAT_BITS-1] ? -W'(PI) : W'(PI);
                  end else begin
                     x <= ext_x;
                     y <= ext_y;
                     z <= '0;
                  end
                  state <= ROTATE;
               end
            end
            ROTATE: begin
               if (y_pos) begin
                  x <= x + y_sh;
                  y <= y - x_sh;
                  z <= z + atan_w;
               end else begin
                  x <= x - y_sh;
                  y <= y + x_sh;
                  z <= z - atan_w;
               end
               iter <= iter + 5'd1;
               if (iter == LAST) state <= SCALE;
            end
            SCALE: begin
               out_mag   <= FLOAT_BITS'(prod >>> FLOAT_DCM_BITS);
               // A null vector never flips d, so z would hold the table sum
               out_angle <= zero_vec ? '0 : FLOAT_BITS'(z);
               state     <= DONE;
            end
            DONE: begin
               if (!out_valid) begin
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_atan2_cordic.sv
// ============================================================================
// tb_atan2_cordic : table-driven and random scoreboard bench for atan2_cordic
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_atan2_cordic;
   import atan2_cordic_pkg::*;

   localparam int ITER    = 16;
   localparam int ANG_TOL = 6;
   localparam int ONE     = 65536;

   typedef struct packed {
      logic signed [31:0] x;
      logic signed [31:0] y;
      logic signed [31:0] ang;
      logic signed [31:0] mag;
   } vec_t;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid, in_ready, out_valid, out_ready;
   logic signed [31:0] in_x, in_y, out_angle, out_mag;

   int   checks = 0;
   int   errors = 0;
   vec_t sb[$];
   vec_t tbl[9];

   always #5 clk = ~clk;

   atan2_cordic #(.ITERATIONS(ITER)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .in_y      (in_y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_angle (out_angle),
      .out_mag   (out_mag)
   );

   task automatic check_tol(input string name, input int act, input int exp, input int tol);
      int diff;
      diff = act - exp;
      if (diff < 0) diff = -diff;
      checks++;
      if (diff > tol) begin
         errors++;
         $display("FAIL %s: actual %0d, required %0d +/- %0d", name, act, exp, tol);
      end
   endtask

   task automatic check_eq(input string name, input int act, input int exp);
      check_tol(name, act, exp, 0);
   endtask

   // bring an angle onto the same 2*pi branch as the expected one
   function automatic int ang_wrap(input int act, input int exp);
      int d;
      d = act - exp;
      if (d > int'(PI))       return act - 2 * int'(PI);
      else if (d < -int'(PI)) return act + 2 * int'(PI);
      return act;
   endfunction

   function automatic int rnd(input real r);
      return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
   endfunction

   task automatic send(input int x, input int y);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: in_ready 0 after %0d cycles, required 1", n);
      end
      in_x     = x;
      in_y     = y;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic collect(output int lat);
      vec_t e;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid) begin
         checks++;
         errors++;
         $display("FAIL result_timeout: out_valid 0 after %0d cycles, required 1", lat);
         if (sb.size() > 0) void'(sb.pop_front());
      end else begin
         e = sb.pop_front();
         check_tol("angle", ang_wrap(out_angle, e.ang), e.ang, ANG_TOL);
         check_tol("mag", out_mag, e.mag, 8 + e.mag / 32768);
      end
   endtask

   task automatic do_vec(input vec_t v, input bit chk_lat);
      int lat;
      sb.push_back(v);
      send(v.x, v.y);
      collect(lat);
      if (out_ready && out_valid) begin
         @(posedge clk); #1;
      end
      if (chk_lat) begin
         check_eq("latency", lat, ITER + 2);
         check_eq("in_ready_after_done", int'(in_ready), 1);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      vec_t v;
      int   lat, seen;

      tbl[0] = '{32'sd65536,   32'sd0,       32'sd0,       32'sd65536};
      tbl[1] = '{32'sd65536,   32'sd65536,   32'sd51472,   32'sd92682};
      tbl[2] = '{-32'sd65536,  32'sd0,       32'sd205887,  32'sd65536};
      tbl[3] = '{-32'sd65536,  -32'sd65536,  -32'sd154416, 32'sd92682};
      tbl[4] = '{32'sd0,       32'sd0,       32'sd0,       32'sd0};
      tbl[5] = '{32'sd0,       32'sd65536,   32'sd102944,  32'sd65536};
      tbl[6] = '{32'sd0,       -32'sd163840, -32'sd102944, 32'sd163840};
      tbl[7] = '{32'sd196608,  32'sd262144,  32'sd60771,   32'sd327680};
      tbl[8] = '{-32'sd196608, 32'sd262144,  32'sd145116,  32'sd327680};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_x = '0; in_y = '0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      check_eq("reset_in_ready", int'(in_ready), 1);
      check_eq("reset_out_valid", int'(out_valid), 0);
      check_eq("reset_out_angle", out_angle, 0);
      check_eq("reset_out_mag", out_mag, 0);

      for (int i = 0; i < 9; i++) do_vec(tbl[i], 1'b1);

      // x<0, y=0 must land on +pi
      v = '{-32'sd131072, 32'sd0, 32'sd205887, 32'sd131072};
      sb.push_back(v);
      send(v.x, v.y);
      collect(lat);
      check_eq("neg_x_zero_y_positive", int'(out_angle > 0), 1);
      @(posedge clk); #1;

      // backpressure: result held, busy requests ignored
      out_ready = 1'b0;
      v = '{32'sd131072, -32'sd65536, -32'sd30386, 32'sd146542};
      sb.push_back(v);
      send(v.x, v.y);
      collect(lat);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check_eq("hold_out_valid", int'(out_valid), 1);
         check_eq("hold_in_ready", int'(in_ready), 0);
         check_tol("hold_angle", out_angle, v.ang, ANG_TOL);
         check_tol("hold_mag", out_mag, v.mag, 8);
         in_valid = ((k % 3) == 0);
         in_x     = 40000 * k + 7;
         in_y     = -3 * ONE;
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check_eq("release_out_valid", int'(out_valid), 0);
      check_eq("release_in_ready", int'(in_ready), 1);
      seen = 0;
      repeat (25) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1;
      end
      check_eq("no_second_accept", seen, 0);

      // reset in flight discards the result
      send(3 * ONE, ONE);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      #1 check_eq("rst_out_valid", int'(out_valid), 0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      check_eq("rst_in_ready", int'(in_ready), 1);
      check_eq("rst_out_angle", out_angle, 0);
      check_eq("rst_out_mag", out_mag, 0);
      seen = 0;
      repeat (25) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1;
      end
      check_eq("rst_discard", seen, 0);

      for (int i = 0; i < 1000; i++) begin
         int rx, ry;
         rx = int'($urandom_range(32'd1073741822)) - 536870911;
         ry = int'($urandom_range(32'd1073741822)) - 536870911;
         v.x   = rx;
         v.y   = ry;
         v.ang = rnd($atan2($itor(ry), $itor(rx)) * 65536.0);
         v.mag = rnd($sqrt($itor(rx) * $itor(rx) + $itor(ry) * $itor(ry)));
         do_vec(v, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
